// File: rtl/fetch_pkg.sv
// Shared fetch definitions: controller state encoding and the default
// instruction-side widths used by the ROM, the decoder and the fetch unit.
package fetch_pkg;

  localparam int FETCH_AW = 12;
  localparam int FETCH_IW = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Program counter and fetch controller: sequences the PC through sequential
// fetch, branches, stalls and halt, and forwards ROM data to decode.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int AW         = FETCH_AW,
  parameter int IW         = FETCH_IW,
  parameter int START_ADDR = 0,
  parameter int CW         = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic [AW-1:0] instr_addr,
  input  logic [IW-1:0] instr_in,
  output logic [IW-1:0] instr_out,
  output logic          instr_valid,
  input  logic          stall,
  input  logic          halt,
  input  logic          branch_en,
  input  logic          branch_abs,
  input  logic [AW-1:0] branch_target,
  output logic [CW-1:0] retired,
  output fetch_state_e  dbg_state
);

  // Handshake: start is a one-cycle request honoured only in IDLE or HALT;
  // instr_valid qualifies instr_out in every RUN cycle, with no backpressure
  // other than stall, which holds the PC and the retired count.

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [CW-1:0] retired_q, retired_d;
  logic [CW-1:0] retired_inc;

  // Saturating increment: the count sticks at all-ones on very long runs.
  assign retired_inc = (retired_q == {CW{1'b1}}) ? retired_q : retired_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    retired_d   = retired_q;
    instr_out   = '0;
    instr_valid = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d   = ST_RUN;
          pc_d      = AW'(START_ADDR);
          retired_d = '0;
        end
      end

      ST_RUN: begin
        instr_out   = instr_in;
        instr_valid = 1'b1;
        if (halt) begin
          state_d   = ST_HALT;
          retired_d = retired_inc;
        end else if (stall) begin
          pc_d      = pc_q;
        end else if (branch_en) begin
          // Relative targets are two's complement; the AW-bit add wraps.
          pc_d      = branch_abs ? branch_target : pc_q + branch_target;
          retired_d = retired_inc;
        end else begin
          pc_d      = pc_q + AW'(1);
          retired_d = retired_inc;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

  assign instr_addr = pc_q;
  assign retired    = retired_q;
  assign done       = (state_q == ST_HALT);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table for the scripted corner
// cases, then random stimulus against an arithmetic reference model.
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam int AW = 12;
  localparam int IW = 9;
  localparam int CW = 16;
  localparam int START_ADDR = 0;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          done;
  logic [AW-1:0] instr_addr;
  logic [IW-1:0] instr_in;
  logic [IW-1:0] instr_out;
  logic          instr_valid;
  logic          stall;
  logic          halt;
  logic          branch_en;
  logic          branch_abs;
  logic [AW-1:0] branch_target;
  logic [CW-1:0] retired;
  fetch_state_e  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_fetch #(
    .AW(AW), .IW(IW), .START_ADDR(START_ADDR), .CW(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .done(done),
    .instr_addr(instr_addr), .instr_in(instr_in), .instr_out(instr_out),
    .instr_valid(instr_valid), .stall(stall), .halt(halt),
    .branch_en(branch_en), .branch_abs(branch_abs),
    .branch_target(branch_target), .retired(retired), .dbg_state(dbg_state)
  );

  // Combinational ROM: contents are an arbitrary scramble of the address.
  function automatic logic [IW-1:0] rom_f(input int a);
    int v;
    v = (a * 37 + 11) ^ (a >> 4);
    return IW'(v);
  endfunction

  always_comb instr_in = rom_f(int'(instr_addr));

  typedef struct {
    logic rst, st, stl, hlt, br, abs_b;
    int   tgt;
    int   e_addr;
    logic e_valid, e_done;
    int   e_ret;
  } vec_t;

  vec_t vq[$];

  // Reference model at spec level: plain integers and modular arithmetic.
  bit m_running, m_done;
  int m_pc, m_ret;

  task automatic model_step(input logic rst, st, stl, hlt, br, abs_b, input int tgt);
    if (rst) begin
      m_running = 0; m_done = 0; m_pc = 0; m_ret = 0;
    end else if (!m_running) begin
      if (st) begin
        m_running = 1; m_done = 0; m_pc = START_ADDR; m_ret = 0;
      end
    end else if (hlt) begin
      m_running = 0; m_done = 1;
      m_ret = (m_ret + 1 > 65535) ? 65535 : m_ret + 1;
    end else if (!stl) begin
      if (br) m_pc = abs_b ? tgt : (m_pc + tgt) % 4096;
      else    m_pc = (m_pc + 1) % 4096;
      m_ret = (m_ret + 1 > 65535) ? 65535 : m_ret + 1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
    end
  endtask

  task automatic apply(input logic rst, st, stl, hlt, br, abs_b, input int tgt);
    @(negedge clk);
    reset = rst; start = st; stall = stl; halt = hlt;
    branch_en = br; branch_abs = abs_b; branch_target = AW'(tgt);
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input int e_addr, input logic e_valid,
                               input logic e_done, input int e_ret);
    check({tag, ".instr_addr"}, int'(instr_addr), e_addr);
    check({tag, ".instr_valid"}, int'(instr_valid), int'(e_valid));
    check({tag, ".done"}, int'(done), int'(e_done));
    check({tag, ".retired"}, int'(retired), e_ret);
    check({tag, ".instr_out"}, int'(instr_out), e_valid ? int'(rom_f(e_addr)) : 0);
  endtask

  task automatic add(input logic rst, st, stl, hlt, br, abs_b, input int tgt,
                     input int ea, input logic ev, ed, input int er);
    vec_t v;
    v = '{rst, st, stl, hlt, br, abs_b, tgt, ea, ev, ed, er};
    vq.push_back(v);
  endtask

  initial begin
    reset = 1'b1; start = 0; stall = 0; halt = 0;
    branch_en = 0; branch_abs = 0; branch_target = '0;

    //  rst st stl hlt br abs tgt     addr  v  d  ret
    add(1, 0, 0, 0, 0, 0, 0,         0,    0, 0, 0);   // reset state
    add(0, 1, 0, 0, 0, 0, 0,         0,    1, 0, 0);   // start
    add(0, 0, 0, 0, 0, 0, 0,         1,    1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0,         2,    1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0,         3,    1, 0, 3);
    add(0, 0, 0, 0, 1, 1, 10,        10,   1, 0, 4);
    add(0, 0, 0, 0, 1, 0, 12'hFFD,   7,    1, 0, 5);   // 10 - 3
    add(0, 0, 0, 0, 1, 1, 4094,      4094, 1, 0, 6);
    add(0, 0, 0, 0, 1, 0, 5,         3,    1, 0, 7);   // relative wrap
    add(0, 0, 0, 0, 1, 1, 20,        20,   1, 0, 8);
    add(0, 0, 1, 0, 1, 1, 100,       20,   1, 0, 8);   // stall beats branch
    add(0, 0, 0, 0, 1, 1, 100,       100,  1, 0, 9);
    add(0, 1, 0, 0, 0, 0, 0,         101,  1, 0, 10);  // start ignored in RUN
    add(0, 0, 0, 0, 1, 1, 30,        30,   1, 0, 11);
    add(0, 0, 0, 1, 0, 0, 0,         30,   0, 1, 12);  // halt
    add(0, 0, 0, 0, 0, 0, 0,         30,   0, 1, 12);
    add(0, 0, 1, 1, 1, 1, 5,         30,   0, 1, 12);  // inputs ignored in HALT
    add(0, 1, 0, 0, 0, 0, 0,         0,    1, 0, 0);   // restart from HALT
    add(0, 0, 0, 0, 1, 1, 57,        57,   1, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0,         0,    0, 0, 0);   // reset mid-run
    add(0, 0, 1, 1, 1, 1, 9,         0,    0, 0, 0);   // IDLE ignores all but start
    add(0, 1, 0, 0, 0, 0, 0,         0,    1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 4094,      4094, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0,         4095, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0,         0,    1, 0, 3);   // sequential wrap
    add(0, 0, 1, 1, 0, 0, 0,         0,    0, 1, 4);   // halt beats stall
    add(1, 1, 0, 0, 0, 0, 0,         0,    0, 0, 0);   // reset beats start

    for (int i = 0; i < vq.size(); i++) begin
      apply(vq[i].rst, vq[i].st, vq[i].stl, vq[i].hlt, vq[i].br, vq[i].abs_b, vq[i].tgt);
      check_outputs($sformatf("vec%0d", i), vq[i].e_addr, vq[i].e_valid,
                    vq[i].e_done, vq[i].e_ret);
    end

    // Hand sequence: long stall keeps PC and count, then resumes.
    apply(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) apply(0, 0, 1, 0, 0, 0, 0);
    check_outputs("stall_hold", 0, 1, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0);
    check_outputs("stall_release", 1, 1, 0, 1);

    // Randomized run against the reference model.
    apply(1, 0, 0, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic r_rst, r_st, r_stl, r_hlt, r_br, r_abs;
      int   r_tgt;
      r_rst = ($urandom_range(0, 299) == 0);
      r_st  = ($urandom_range(0, 14) == 0);
      r_stl = ($urandom_range(0, 3) == 0);
      r_hlt = ($urandom_range(0, 59) == 0);
      r_br  = ($urandom_range(0, 4) == 0);
      r_abs = 1'($urandom_range(0, 1));
      r_tgt = int'($urandom_range(0, 4095));
      apply(r_rst, r_st, r_stl, r_hlt, r_br, r_abs, r_tgt);
      model_step(r_rst, r_st, r_stl, r_hlt, r_br, r_abs, r_tgt);
      check_outputs($sformatf("rnd%0d", i), m_pc, m_running, m_done, m_ret);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Program-counter and fetch controller that drives the address side of the instruction ROM (12-bit address, 9-bit instruction) and hands each fetched instruction to decode. It owns the start/done handshake with the testbench or top level and sequences the PC through sequential fetch, branches, stalls and halt. It sits between the top-level control and the instruction ROM / decoder.

## Interface
- AW, 12, instruction address width (ROM depth 2^AW)
- IW, 9, instruction width
- START_ADDR, 0, PC value loaded on start
- CW, 16, retired-instruction counter width

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a program run
- done  out  1  high while halted after a completed run
- instr_addr  out  AW  address to instruction ROM (= PC)
- instr_in  in  IW  instruction from ROM (combinational read of instr_addr)
- instr_out  out  IW  instruction to decode
- instr_valid  out  1  instr_out is a live instruction this cycle
- stall  in  1  hold PC this cycle
- halt  in  1  decode saw the halt instruction this cycle
- branch_en  in  1  take a branch this cycle
- branch_abs  in  1  1: absolute target, 0: PC-relative
- branch_target  in  AW  absolute target or signed two's-complement offset
- retired  out  CW  number of instructions retired in the current/last run

## Operation
- States: IDLE, RUN, HALT. Reset: state IDLE, PC 0, retired 0, done 0.
- IDLE: start -> RUN, PC <= START_ADDR, retired <= 0. All other inputs ignored.
- RUN: instr_out = instr_in, instr_valid = 1; otherwise instr_out = 0, instr_valid = 0.
- RUN priority per cycle: halt > stall > branch_en > sequential.
  - halt: state -> HALT, PC held, retired += 1 (halt counts as retired).
  - stall: PC and retired held; branch_en ignored.
  - branch_en, branch_abs=1: PC <= branch_target; retired += 1.
  - branch_en, branch_abs=0: PC <= PC + branch_target, modulo 2^AW; retired += 1.
  - else: PC <= PC + 1, modulo 2^AW (4095 -> 0); retired += 1.
- retired saturates at 2^CW-1.
- start during RUN ignored.
- HALT: done = 1, PC and retired held. start -> RUN with the same actions as from IDLE; done drops with the state change.
- reset in any state, including mid-run, overrides everything and returns to IDLE the next cycle.

## Timing
- All state registered on posedge clk. instr_addr = PC register, so there is no combinational path from inputs to instr_addr.
- Fetch is zero-latency: the instruction for PC appears on instr_out in the same cycle through the combinational ROM.
- start sampled high at edge N -> from N+1: instr_addr = START_ADDR, instr_valid = 1, done = 0.
- halt sampled at edge N -> from N+1: done = 1, instr_valid = 0.
- The branch target is visible on instr_addr in the cycle after branch_en. There is no delay slot and no flush.
- done is a decode of the registered state (state==HALT); it has no glitch path from inputs.

## Structure
- Shared package fetch_pkg holds:
  - the state enum (IDLE, RUN, HALT);
  - default AW/IW constants, shared with the ROM and decoder.
- Single module. The next-PC mux and adder are small enough to stay inline; no sub-module.

## Test plan
- Reset then start: instr_addr sequence 0,1,2,3 on successive cycles, instr_valid = 1, retired = 3 after the 3rd edge.
- Relative branch: at PC=10, branch_en=1, branch_abs=0, target=12'hFFD (-3) -> next instr_addr = 7. Same with target=5 at PC=4094 -> 3 (wrap).
- Absolute branch while stalled: at PC=20, stall=1 with branch_en=1, target=100 -> PC stays 20. Next cycle branch_en only -> PC = 100.
- Halt:
  - halt at PC=30 -> done = 1 next cycle, instr_addr = 30, instr_valid = 0, retired unchanged afterwards.
  - start -> PC = 0, done = 0, retired = 0.
- Reset mid-run at PC=57 -> next cycle IDLE, PC = 0, done = 0, instr_valid = 0. start during RUN has no effect on PC.
- Sequential wrap: PC reaches 4095 -> next instr_addr = 0, still RUN.
